// File: rtl/lr_bus_pkg.sv
// Shared constants and types for the lr35902 memory-bus responder.
// Optional build macro LR_BUS_ECHO_EN selects echo-RAM mapping (used by lr_bus and lr_dma).
package lr_bus_pkg;

  localparam int unsigned DMA_LEN    = 160;
  localparam int unsigned DMA_SETUP  = 1;
  localparam logic [7:0]  SETUP_LAST = 8'(DMA_SETUP - 1);
  localparam logic [7:0]  LEN_LAST   = 8'(DMA_LEN - 1);

  localparam logic [15:0] EXT_LIMIT    = 16'hDFFF;
  localparam logic [15:0] ECHO_LIMIT   = 16'hFDFF;
  localparam logic [15:0] ECHO_OFFSET  = 16'h2000;
  localparam logic [15:0] OAM_LIMIT    = 16'hFE9F;
  localparam logic [15:0] UNUSED_LIMIT = 16'hFEFF;
  localparam logic [15:0] IO_LIMIT     = 16'hFF7F;
  localparam logic [15:0] HRAM_LIMIT   = 16'hFFFE;
  localparam logic [15:0] ADDR_IF      = 16'hFF0F;
  localparam logic [15:0] ADDR_DMA     = 16'hFF46;
  localparam logic [15:0] ADDR_IE      = 16'hFFFF;

  localparam logic [7:0]  ECHO_SRC_BASE  = 8'hE0;
  localparam logic [7:0]  ECHO_SRC_DELTA = 8'h20;

  localparam int unsigned HRAM_DEPTH = 128;

  typedef enum logic [1:0] {StIdle, StSetup, StXfer} dma_state_e;

  typedef enum logic [3:0] {
    RegExt, RegEcho, RegOam, RegUnused, RegIo, RegIf, RegDma, RegHram, RegIe
  } region_e;

  function automatic region_e decode_region(input logic [15:0] addr);
    region_e r;
    if (addr <= EXT_LIMIT)         r = RegExt;
    else if (addr <= ECHO_LIMIT)   r = RegEcho;
    else if (addr <= OAM_LIMIT)    r = RegOam;
    else if (addr <= UNUSED_LIMIT) r = RegUnused;
    else if (addr == ADDR_IF)      r = RegIf;
    else if (addr == ADDR_DMA)     r = RegDma;
    else if (addr <= IO_LIMIT)     r = RegIo;
    else if (addr <= HRAM_LIMIT)   r = RegHram;
    else                           r = RegIe;
    return r;
  endfunction

endpackage

// File: rtl/lr_dma.sv
// OAM DMA engine: FF46 source register, setup delay, then one byte per cycle into OAM.
// With LR_BUS_ECHO_EN defined, sources E0-FF are folded down by 0x20 onto WRAM.
module lr_dma
  import lr_bus_pkg::*;
(
  input  logic        clock4,
  input  logic        resetn,
  input  logic        i_start,
  input  logic [7:0]  i_src,
  output logic        o_busy,
  output logic        o_xfer,
  output logic [7:0]  o_src,
  output logic [15:0] o_ext_addr,
  output logic [7:0]  o_oam_addr
);

  dma_state_e r_state, w_state_next;
  logic [7:0] r_src;
  logic [7:0] r_idx, w_idx_next;
  logic [7:0] w_src_eff;

  always_ff @(posedge clock4 or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
      r_src   <= 8'hFF;
      r_idx   <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      if (i_start) r_src <= i_src;
    end
  end

  // r_idx counts setup cycles in StSetup and is the byte index in StXfer.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    if (i_start) begin
      w_state_next = StSetup;
      w_idx_next   = 8'h00;
    end else begin
      case (r_state)
        StSetup: begin
          if (r_idx == SETUP_LAST) begin
            w_state_next = StXfer;
            w_idx_next   = 8'h00;
          end else begin
            w_idx_next = r_idx + 8'd1;
          end
        end
        StXfer: begin
          if (r_idx == LEN_LAST) begin
            w_state_next = StIdle;
            w_idx_next   = 8'h00;
          end else begin
            w_idx_next = r_idx + 8'd1;
          end
        end
        StIdle:  w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

`ifdef LR_BUS_ECHO_EN
  assign w_src_eff = (r_src >= ECHO_SRC_BASE) ? (r_src - ECHO_SRC_DELTA) : r_src;
`else
  assign w_src_eff = r_src;
`endif

  assign o_busy     = (r_state != StIdle);
  assign o_xfer     = (r_state == StXfer);
  assign o_src      = r_src;
  assign o_ext_addr = {w_src_eff, r_idx};
  assign o_oam_addr = r_idx;

endmodule

// File: rtl/lr_bus.sv
// lr35902 memory-bus responder: decode, HRAM, IE/IF, OAM DMA, ext/OAM/IO routing.
// Build macro LR_BUS_ECHO_EN maps E000-FDFF onto ext at addr-0x2000.
module lr_bus
  import lr_bus_pkg::*;
(
  input  logic        clock4,
  input  logic        resetn,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic [7:0]  o_cpu_rdata,
  input  logic        i_load,
  input  logic        i_store,
  output logic [15:0] o_ext_addr,
  input  logic [7:0]  i_ext_rdata,
  output logic [7:0]  o_ext_wdata,
  output logic        o_ext_re,
  output logic        o_ext_we,
  output logic [7:0]  o_oam_addr,
  input  logic [7:0]  i_oam_rdata,
  output logic [7:0]  o_oam_wdata,
  output logic        o_oam_we,
  output logic [6:0]  o_io_addr,
  input  logic [7:0]  i_io_rdata,
  output logic [7:0]  o_io_wdata,
  output logic        o_io_re,
  output logic        o_io_we,
  input  logic [4:0]  i_irq_req,
  input  logic [4:0]  i_irq_ack,
  output logic        o_irq_pending,
  output logic        o_dma_busy
);

  logic [4:0]  r_if;
  logic [7:0]  r_ie;
  logic [7:0]  r_hram [HRAM_DEPTH];

  region_e     w_region;
  logic        w_access, w_cpu_blocked;
  logic [7:0]  w_rd;
  logic [15:0] w_cpu_ext_addr;
  logic        w_cpu_ext_re, w_cpu_ext_we;
  logic [7:0]  w_cpu_oam_addr;
  logic        w_cpu_oam_we;
  logic [6:0]  w_io_addr;
  logic        w_io_re, w_io_we;
  logic        w_hram_we, w_if_we, w_ie_we, w_dma_start;
  logic        w_dma_busy, w_dma_xfer;
  logic [7:0]  w_dma_src, w_dma_oam_addr;
  logic [15:0] w_dma_ext_addr;

  lr_dma u_dma (
    .clock4     (clock4),
    .resetn     (resetn),
    .i_start    (w_dma_start),
    .i_src      (i_cpu_wdata),
    .o_busy     (w_dma_busy),
    .o_xfer     (w_dma_xfer),
    .o_src      (w_dma_src),
    .o_ext_addr (w_dma_ext_addr),
    .o_oam_addr (w_dma_oam_addr)
  );

  assign w_region      = decode_region(i_cpu_addr);
  assign w_access      = i_load | i_store;
  // While DMA owns the bus, everything below FF00 is invisible to the CPU.
  assign w_cpu_blocked = w_dma_busy & (i_cpu_addr <= UNUSED_LIMIT);

  always_comb begin
    w_rd           = 8'h00;
    w_cpu_ext_addr = 16'h0000;
    w_cpu_ext_re   = 1'b0;
    w_cpu_ext_we   = 1'b0;
    w_cpu_oam_addr = 8'h00;
    w_cpu_oam_we   = 1'b0;
    w_io_addr      = 7'h00;
    w_io_re        = 1'b0;
    w_io_we        = 1'b0;
    w_hram_we      = 1'b0;
    w_if_we        = 1'b0;
    w_ie_we        = 1'b0;
    w_dma_start    = 1'b0;
    if (w_cpu_blocked) begin
      w_rd = 8'hFF;
    end else if (w_access) begin
      unique case (w_region)
        RegExt: begin
          w_cpu_ext_addr = i_cpu_addr;
          w_cpu_ext_re   = i_load;
          w_cpu_ext_we   = i_store;
          w_rd           = i_ext_rdata;
        end
        RegEcho: begin
`ifdef LR_BUS_ECHO_EN
          w_cpu_ext_addr = i_cpu_addr - ECHO_OFFSET;
          w_cpu_ext_re   = i_load;
          w_cpu_ext_we   = i_store;
          w_rd           = i_ext_rdata;
`else
          w_rd = 8'hFF;
`endif
        end
        RegOam: begin
          w_cpu_oam_addr = i_cpu_addr[7:0];
          w_cpu_oam_we   = i_store;
          w_rd           = i_oam_rdata;
        end
        RegUnused: w_rd = 8'h00;
        RegIo: begin
          w_io_addr = i_cpu_addr[6:0];
          w_io_re   = i_load;
          w_io_we   = i_store;
          w_rd      = i_io_rdata;
        end
        RegIf: begin
          w_rd    = {3'b111, r_if};
          w_if_we = i_store;
        end
        RegDma: begin
          w_rd        = w_dma_src;
          w_dma_start = i_store;
        end
        RegHram: begin
          w_rd      = r_hram[i_cpu_addr[6:0]];
          w_hram_we = i_store;
        end
        RegIe: begin
          w_rd    = r_ie;
          w_ie_we = i_store;
        end
        default: w_rd = 8'h00;
      endcase
    end
  end

  // Set pulses win over both the ack clear and a CPU write in the same cycle.
  always_ff @(posedge clock4 or negedge resetn) begin
    if (!resetn) begin
      r_if <= 5'h00;
      r_ie <= 8'h00;
    end else begin
      r_if <= ((w_if_we ? i_cpu_wdata[4:0] : r_if) & ~i_irq_ack) | i_irq_req;
      if (w_ie_we) r_ie <= i_cpu_wdata;
    end
  end

  always_ff @(posedge clock4) begin
    if (w_hram_we) r_hram[i_cpu_addr[6:0]] <= i_cpu_wdata;
  end

  assign o_cpu_rdata   = i_load ? w_rd : 8'h00;
  assign o_ext_addr    = w_dma_xfer ? w_dma_ext_addr : w_cpu_ext_addr;
  assign o_ext_re      = w_dma_xfer | w_cpu_ext_re;
  assign o_ext_we      = w_cpu_ext_we;
  assign o_ext_wdata   = w_cpu_ext_we ? i_cpu_wdata : 8'h00;
  assign o_oam_addr    = w_dma_xfer ? w_dma_oam_addr : w_cpu_oam_addr;
  assign o_oam_we      = w_dma_xfer | w_cpu_oam_we;
  assign o_oam_wdata   = w_dma_xfer ? i_ext_rdata : (w_cpu_oam_we ? i_cpu_wdata : 8'h00);
  assign o_io_addr     = w_io_addr;
  assign o_io_re       = w_io_re;
  assign o_io_we       = w_io_we;
  assign o_io_wdata    = w_io_we ? i_cpu_wdata : 8'h00;
  assign o_irq_pending = |(r_ie[4:0] & r_if);
  assign o_dma_busy    = w_dma_busy;

endmodule
